// File: rtl/rf_port_arbiter_pkg.sv
// Shared types and default widths for the register-file port arbiter.
package rf_port_arbiter_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_LOCKED
  } arb_state_t;

endpackage

// File: rtl/rf_port_arbiter_rr_pick.sv
// Combinational round-robin pick: first unmasked request at or above ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [IW-1:0]   id
);

  int j;

  always_comb begin
    found = 1'b0;
    id    = '0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j] && !mask[j]) begin
        found = 1'b1;
        id    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// Round-robin sequencer sharing an external register bank between NREQ requesters.
// Grant one cycle after request, read data one cycle after grant; bounded lock bursts.
module rf_port_arbiter
  import rf_port_arbiter_pkg::*;
#(
  parameter int  NREQ     = 4,
  parameter int  NREG     = 8,
  parameter int  AW       = AW_DEF,
  parameter int  DW       = DW_DEF,
  parameter int  LOCK_MAX = 4,
  localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW       = $clog2(LOCK_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ-1:0]      lock,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [DW-1:0]        rdata,
  output logic                 rvalid,
  output logic [IW-1:0]        rid,
  output logic                 err,
  output logic [NREG-1:0]      rf_wr_en,
  output logic [DW-1:0]        rf_wdata,
  input  logic [NREG*DW-1:0]   rf_rdata
);

  arb_state_t      state;
  logic [IW-1:0]   ptr, cur_id, win, pick_id;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            pick_found, take, arb, hold_lock, op_vld, op_we, in_range;
  logic [AW-1:0]   op_addr, win_addr;
  logic [DW-1:0]   rd_sel;
  logic [NREQ-1:0] mask, gnt_nxt;
  logic [NREG-1:0] wr_en_nxt;

  // A locked owner may be served in consecutive cycles; otherwise the last grantee sits out once.
  assign mask = (state == ST_LOCKED) ? '0 : gnt;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (req),
    .mask  (mask),
    .ptr   (ptr),
    .found (pick_found),
    .id    (pick_id)
  );

  always_comb begin
    arb       = 1'b0;
    take      = 1'b0;
    win       = pick_id;
    hold_lock = 1'b0;
    cnt_nxt   = cnt;
    if (state == ST_LOCKED) begin
      if (req[cur_id]) begin
        take      = 1'b1;
        win       = cur_id;
        cnt_nxt   = cnt + 1'b1;
        hold_lock = lock[cur_id] && (int'(cnt) + 1 < LOCK_MAX);
      end else if (lock[cur_id]) begin
        hold_lock = 1'b1;
      end else begin
        arb = 1'b1;
      end
    end else begin
      arb = 1'b1;
    end
    if (arb && pick_found) begin
      take      = 1'b1;
      win       = pick_id;
      cnt_nxt   = CW'(1);
      hold_lock = lock[pick_id] && (LOCK_MAX > 1);
    end
  end

  always_comb begin
    win_addr  = addr[int'(win)*AW +: AW];
    in_range  = int'(win_addr) < NREG;
    gnt_nxt   = '0;
    gnt_nxt[win] = take;
    wr_en_nxt = '0;
    for (int r = 0; r < NREG; r++) begin
      wr_en_nxt[r] = take && we[win] && (int'(win_addr) == r);
    end
    rd_sel = '0;
    for (int r = 0; r < NREG; r++) begin
      if (int'(op_addr) == r) rd_sel = rf_rdata[r*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ptr      <= '0;
      cur_id   <= '0;
      gnt      <= '0;
      rf_wr_en <= '0;
      rf_wdata <= '0;
      err      <= 1'b0;
      op_vld   <= 1'b0;
      op_we    <= 1'b0;
      op_addr  <= '0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rid      <= '0;
    end else begin
      state    <= hold_lock ? ST_LOCKED : (take ? ST_GRANT : ST_IDLE);
      cnt      <= hold_lock ? cnt_nxt : '0;
      gnt      <= gnt_nxt;
      rf_wr_en <= wr_en_nxt;
      err      <= take && !in_range;
      op_vld   <= take;
      if (take) begin
        cur_id   <= win;
        ptr      <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
        op_we    <= we[win];
        op_addr  <= win_addr;
        rf_wdata <= wdata[int'(win)*DW +: DW];
      end
      rvalid <= op_vld && !op_we;
      if (op_vld && !op_we) begin
        rdata <= rd_sel;
        rid   <= cur_id;
      end
    end
  end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Self-checking bench for rf_port_arbiter with a 6-register bank model and randomized scoreboard run.
module tb_rf_port_arbiter;

  localparam int NREQ = 4, NREG = 6, AW = 3, DW = 16, LOCK_MAX = 4;

  logic                clk, rst_n;
  logic [NREQ-1:0]     req, we, lock;
  logic [NREQ*AW-1:0]  addr;
  logic [NREQ*DW-1:0]  wdata;
  logic [NREQ-1:0]     gnt;
  logic [DW-1:0]       rdata;
  logic                rvalid;
  logic [1:0]          rid;
  logic                err;
  logic [NREG-1:0]     rf_wr_en;
  logic [DW-1:0]       rf_wdata;
  logic [NREG*DW-1:0]  rf_rdata;
  logic [DW-1:0]       bank [NREG];
  bit                  bank_loaded;
  int                  checks, errors;

  rf_port_arbiter #(.NREQ(NREQ), .NREG(NREG), .AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .lock(lock), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .rid(rid), .err(err),
    .rf_wr_en(rf_wr_en), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External bank of reg16 registers; not reset, preloaded once.
  always @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (!bank_loaded) bank[r] <= 16'h0A00 + 16'(r);
      else if (rf_wr_en[r]) bank[r] <= rf_wdata;
    end
  end

  always_comb begin
    rf_rdata = '0;
    for (int r = 0; r < NREG; r++) rf_rdata[r*DW +: DW] = bank[r];
  end

  task automatic set_op(input int i, input bit w, input bit l, input int a, input logic [DW-1:0] d);
    we[i] = w;
    lock[i] = l;
    addr[i*AW +: AW] = a[AW-1:0];
    wdata[i*DW +: DW] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = '0;
    lock = '0;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (gnt !== 4'b0 || rf_wr_en !== 6'b0) begin errors++;
      $display("FAIL reset_gnt_wren: gnt=%b wr_en=%b want 0", gnt, rf_wr_en); end
    checks++; if (rvalid !== 1'b0 || rdata !== 16'h0 || rid !== 2'd0) begin errors++;
      $display("FAIL reset_read: rvalid=%b rdata=%h rid=%0d want 0", rvalid, rdata, rid); end
    checks++; if (err !== 1'b0 || rf_wdata !== 16'h0) begin errors++;
      $display("FAIL reset_err_wdata: err=%b rf_wdata=%h want 0", err, rf_wdata); end
    do_reset();
  endtask

  task automatic test_write();
    set_op(2, 1'b1, 1'b0, 5, 16'hBEEF);
    req = 4'b0100;
    step();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL wr_gnt: got %b want 0100", gnt); end
    checks++; if (rf_wr_en !== 6'b100000) begin errors++; $display("FAIL wr_en: got %b want 100000", rf_wr_en); end
    checks++; if (rf_wdata !== 16'hBEEF || err !== 1'b0) begin errors++;
      $display("FAIL wr_data: wdata=%h err=%b want BEEF 0", rf_wdata, err); end
    req = '0;
    step();
    checks++; if (bank[5] !== 16'hBEEF) begin errors++; $display("FAIL wr_bank: got %h want BEEF", bank[5]); end
    checks++; if (gnt !== 4'b0 || rf_wr_en !== 6'b0) begin errors++;
      $display("FAIL wr_done: gnt=%b wr_en=%b want 0", gnt, rf_wr_en); end
  endtask

  task automatic test_read_back();
    set_op(0, 1'b0, 1'b0, 5, 16'h0);
    req = 4'b0001;
    step();
    checks++; if (gnt !== 4'b0001 || rvalid !== 1'b0) begin errors++;
      $display("FAIL rd_gnt: gnt=%b rvalid=%b want 0001 0", gnt, rvalid); end
    req = '0;
    step();
    checks++; if (rvalid !== 1'b1 || rdata !== 16'hBEEF || rid !== 2'd0 || err !== 1'b0) begin errors++;
      $display("FAIL rd_data: rvalid=%b rdata=%h rid=%0d err=%b want 1 BEEF 0 0", rvalid, rdata, rid, err); end
    step();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rd_pulse: rvalid=%b want 0", rvalid); end
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] eg;
    logic [1:0] er;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 1'b0, 1'b0, i, 16'h0);
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      eg = 4'b0001 << (k % 4);
      checks++; if (gnt !== eg) begin errors++; $display("FAIL cont_gnt[%0d]: got %b want %b", k, gnt, eg); end
      if (k >= 1) begin
        er = 2'((k - 1) % 4);
        checks++; if (rvalid !== 1'b1 || rid !== er) begin errors++;
          $display("FAIL cont_rid[%0d]: rvalid=%b rid=%0d want 1 %0d", k, rvalid, rid, er); end
      end
    end
    idle();
    idle();
  endtask

  task automatic test_lock_burst();
    logic [NREQ-1:0] eg;
    logic [NREG-1:0] ew;
    do_reset();
    set_op(1, 1'b1, 1'b1, 0, 16'h1000);
    set_op(2, 1'b0, 1'b0, 1, 16'h0);
    set_op(3, 1'b0, 1'b0, 2, 16'h0);
    req = 4'b1110;
    for (int k = 0; k < 6; k++) begin
      step();
      eg = (k < 4) ? 4'b0010 : ((k == 4) ? 4'b0100 : 4'b1000);
      checks++; if (gnt !== eg) begin errors++; $display("FAIL lock_gnt[%0d]: got %b want %b", k, gnt, eg); end
      if (k < 4) begin
        ew = 6'b1 << k;
        checks++; if (rf_wr_en !== ew) begin errors++; $display("FAIL lock_wren[%0d]: got %b want %b", k, rf_wr_en, ew); end
        set_op(1, 1'b1, 1'b1, k + 1, 16'h1000 + 16'(k + 1));
      end
    end
    for (int r = 0; r < 4; r++) begin
      checks++; if (bank[r] !== 16'h1000 + 16'(r)) begin errors++;
        $display("FAIL lock_bank[%0d]: got %h want %h", r, bank[r], 16'h1000 + 16'(r)); end
    end
    idle();
    idle();
  endtask

  task automatic test_out_of_range();
    set_op(3, 1'b1, 1'b0, 7, 16'hDEAD);
    req = 4'b1000;
    step();
    checks++; if (gnt !== 4'b1000 || rf_wr_en !== 6'b0 || err !== 1'b1) begin errors++;
      $display("FAIL oor_wr: gnt=%b wr_en=%b err=%b want 1000 0 1", gnt, rf_wr_en, err); end
    req = '0;
    step();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL oor_err_pulse: err=%b want 0", err); end
    set_op(0, 1'b0, 1'b0, 6, 16'h0);
    req = 4'b0001;
    step();
    checks++; if (gnt !== 4'b0001 || err !== 1'b1) begin errors++;
      $display("FAIL oor_rd_gnt: gnt=%b err=%b want 0001 1", gnt, err); end
    req = '0;
    step();
    checks++; if (rvalid !== 1'b1 || rdata !== 16'h0 || err !== 1'b0) begin errors++;
      $display("FAIL oor_rd: rvalid=%b rdata=%h err=%b want 1 0 0", rvalid, rdata, err); end
    idle();
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] old;
    old = bank[4];
    set_op(1, 1'b1, 1'b0, 4, ~old);
    req = 4'b0010;
    step();
    checks++; if (gnt !== 4'b0010 || rf_wr_en !== 6'b010000) begin errors++;
      $display("FAIL arst_pre: gnt=%b wr_en=%b want 0010 010000", gnt, rf_wr_en); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0 || rf_wr_en !== 6'b0) begin errors++;
      $display("FAIL arst_drop: gnt=%b wr_en=%b want 0", gnt, rf_wr_en); end
    req = '0;
    step();
    checks++; if (bank[4] !== old) begin errors++; $display("FAIL arst_bank: got %h want %h", bank[4], old); end
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, 1'b0, 1'b0, i, 16'h0);
    req = 4'b1111;
    step();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL arst_ptr: got %b want 0001", gnt); end
    req = 4'b1000;
    step();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL arst_req3: got %b want 1000", gnt); end
    idle();
    idle();
  endtask

  // Reference model: ops are serialised in grant order, so a plain memory array updated at
  // decision time gives the value each read must return.
  task automatic test_random();
    logic [DW-1:0]   mem [NREG];
    int              m_ptr, m_owner, m_cnt, m_last, win, mk, a;
    bit              m_locked, search, p_read;
    logic [NREQ-1:0] e_gnt;
    logic [NREG-1:0] e_wr;
    logic [DW-1:0]   e_wd, e_rd, p_rd;
    logic            e_err, e_rv;
    logic [1:0]      e_rid, p_id;
    do_reset();
    for (int r = 0; r < NREG; r++) mem[r] = bank[r];
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_last = -1; m_locked = 0;
    e_gnt = '0; e_wr = '0; e_wd = '0; e_err = 0; e_rv = 0; e_rd = '0; e_rid = '0;
    p_read = 0; p_rd = '0; p_id = '0;
    for (int c = 0; c < 800; c++) begin
      checks++; if (gnt !== e_gnt) begin errors++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, gnt, e_gnt); end
      checks++; if (rf_wr_en !== e_wr || err !== e_err) begin errors++;
        $display("FAIL rnd_wr c%0d: wr_en=%b err=%b want %b %b", c, rf_wr_en, err, e_wr, e_err); end
      checks++; if (rvalid !== e_rv) begin errors++; $display("FAIL rnd_rvalid c%0d: got %b want %b", c, rvalid, e_rv); end
      if (e_wr != '0) begin
        checks++; if (rf_wdata !== e_wd) begin errors++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, rf_wdata, e_wd); end
      end
      if (e_rv) begin
        checks++; if (rdata !== e_rd || rid !== e_rid) begin errors++;
          $display("FAIL rnd_rdata c%0d: rdata=%h rid=%0d want %h %0d", c, rdata, rid, e_rd, e_rid); end
      end
      for (int i = 0; i < NREQ; i++) begin
        req[i] = ($urandom_range(9) < 6);
        set_op(i, 1'($urandom_range(1)), ($urandom_range(3) == 0), int'($urandom_range(7)), 16'($urandom));
      end
      e_rv = p_read; e_rd = p_rd; e_rid = p_id;
      win = -1;
      search = 0;
      mk = m_locked ? -1 : m_last;
      if (m_locked) begin
        if (req[m_owner]) begin
          win = m_owner;
          m_cnt++;
          if (!lock[m_owner] || m_cnt >= LOCK_MAX) m_locked = 0;
        end else if (!lock[m_owner]) begin
          m_locked = 0;
          search = 1;
        end
      end else begin
        search = 1;
      end
      if (search) begin
        for (int k = 0; k < NREQ; k++) begin
          if (win < 0 && req[(m_ptr + k) % NREQ] && ((m_ptr + k) % NREQ) != mk) win = (m_ptr + k) % NREQ;
        end
        if (win >= 0 && lock[win] && LOCK_MAX > 1) begin
          m_locked = 1; m_owner = win; m_cnt = 1;
        end
      end
      m_last = win;
      e_gnt = '0; e_wr = '0; e_err = 0; p_read = 0;
      if (win >= 0) begin
        m_ptr = (win + 1) % NREQ;
        a = int'(addr[win*AW +: AW]);
        e_gnt = 4'b0001 << win;
        e_err = (a >= NREG);
        e_wd = wdata[win*DW +: DW];
        p_id = 2'(win);
        p_read = !we[win];
        p_rd = (a < NREG) ? mem[a] : 16'h0;
        if (we[win] && a < NREG) begin
          e_wr = 6'b1 << a;
          mem[a] = wdata[win*DW +: DW];
        end
      end
      step();
    end
    idle();
  endtask

  initial begin
    checks = 0; errors = 0; bank_loaded = 0;
    rst_n = 1'b0;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    step();
    bank_loaded = 1;
    test_reset();
    test_write();
    test_read_back();
    test_contention();
    test_lock_burst();
    test_out_of_range();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_port_arbiter.md
Name: rf_port_arbiter

Overview:
- Round-robin arbiter and sequencer for a bank of NREG 16-bit registers built from reg16 instances.
- Shares the bank between NREQ requesters, for example fetch/decode read, writeback and debug port.
- Serialises their read/write operations, drives the bank's per-register wr_en/write lines, and returns registered read data.
- Optional lock holds the bank for one requester for short bursts.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NREG, 8, number of registers in the bank.
- AW, 3, register address width; NREG <= 2**AW.
- DW, 16, data width.
- LOCK_MAX, 4, maximum operations per locked burst before forced release.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester operation request (level).
- we  in  NREQ  1=write, 0=read, per requester.
- lock  in  NREQ  request to keep the bank after this operation.
- addr  in  NREQ*AW  flattened register address, requester i at [i*AW +: AW].
- wdata  in  NREQ*DW  flattened write data.
- gnt  out  NREQ  one-hot grant; high in the cycle the operation executes.
- rdata  out  DW  registered read data.
- rvalid  out  1  rdata valid pulse.
- rid  out  $clog2(NREQ)  requester owning rdata.
- err  out  1  pulse: granted operation had addr >= NREG.
- rf_wr_en  out  NREG  one-hot write enable to bank registers.
- rf_wdata  out  DW  write data broadcast to bank.
- rf_rdata  in  NREG*DW  flattened bank read outputs.

Behaviour:
- Reset (rst_n low, async): gnt=0, rvalid=0, rdata=0, rid=0, err=0, rf_wr_en=0, rf_wdata=0, pointer=0, state=IDLE, lock count=0.
  - Reset mid-operation aborts a pending write: rf_wr_en drops immediately because it is register-derived.
- Timing:
  - Cycle T: req sampled.
  - Edge ending T: winner's id, we, addr and wdata are captured.
  - Cycle T+1: gnt[id]=1. If write and addr<NREG, rf_wr_en[addr]=1 and rf_wdata=captured data, so the bank updates at the edge ending T+1.
  - Read: rf_rdata[addr] captured at the edge ending T+1; rdata, rid and rvalid=1 during T+2.
  - Read latency is 2 cycles from request; throughput is 1 operation per cycle.
- Winner selection: first requester with req=1 searching from pointer upward, with wrap. After a grant to i, pointer = (i+1) mod NREQ.
- Masking: in a cycle where gnt[i]=1, requester i's req is ignored for the next capture unless state=LOCKED. A requester deasserts or changes its req after seeing gnt.
- States:
  - IDLE: no captured operation. Any req -> GRANT.
  - GRANT: one operation executing. If winner's lock=1 at capture -> LOCKED, count=1. Else, any unmasked req -> GRANT, otherwise -> IDLE.
  - LOCKED: only the owner is served. Each cycle with owner req=1 issues an operation and count increments.
  - Exit LOCKED when owner lock=0 at sampling, or when count reaches LOCK_MAX (forced release). On exit the pointer advances past the owner. Owner req=0 while locked idles with no grant; the bank stays reserved.
- Same-register read-after-write in consecutive grants returns the new value, since the write lands before the read capture.
- addr >= NREG: no rf_wr_en, read returns 0 with rvalid=1, err pulses in the grant cycle.
- Simultaneous read and write grants are impossible; at most one gnt bit is high.
- NREQ=1 degenerates to pass-through with 1-cycle grant latency.

Decomposition:
- Shared package: state encoding (IDLE/GRANT/LOCKED), default widths DW=16 and AW=3.
- One sub-module: rr_pick. Combinational round-robin priority encoder taking req, mask and pointer; outputs found and winner id.
- The bank itself is external (NREG reg16 instances wired to rf_wr_en/rf_wdata/rf_rdata).

Test Plan:
- Reset then single write: req[2]=1, we=1, addr=5, wdata=16'hBEEF at T -> gnt[2] and rf_wr_en=8'b0010_0000 at T+1; bank reg5=16'hBEEF afterwards.
- Read back: req[0] read addr=5 -> rdata=16'hBEEF, rid=0, rvalid=1 at T+2; err=0.
- Contention: req=4'b1111 held, all reads -> gnt order 0,1,2,3,0,... one per cycle; pointer wraps 3->0.
- Lock burst: requester 1 lock=1 with 6 writes queued, others requesting -> exactly LOCK_MAX=4 consecutive gnt[1], then gnt[2] next.
- Out of range: NREG=6, write addr=7 -> gnt high, rf_wr_en=0, err=1 for one cycle; read addr=6 -> rdata=0, rvalid=1.
- Async reset during a write grant cycle -> rf_wr_en and gnt drop immediately; target register unchanged; after release the first req[3] is granted, with pointer back at 0.
